// File: rtl/writeback_arbiter_unit_pkg.sv
// Shared micro-architecture definitions for the X->W writeback path.
// Holds the X->W message layout, default widths and small helpers.
package writeback_arbiter_unit_pkg;

  localparam int REG_BITS = 5;
  localparam int XLEN     = 32;
  localparam int SEQ_BITS = 5;

  // X->W message as produced by an execute pipe (default widths).
  typedef struct packed {
    logic [SEQ_BITS-1:0] seq_num;
    logic [REG_BITS-1:0] waddr;
    logic [XLEN-1:0]     wdata;
    logic                wen;
  } x_w_t;

  // x0 is hardwired to zero, so a write to it is never a real write.
  function automatic logic rf_wen(
    input logic                wen,
    input logic [REG_BITS-1:0] waddr
  );
    return wen & (waddr != '0);
  endfunction

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_unit_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Ports: req, ptr in; grant (one-hot), grant_idx, gnt_any out.
module rr_arbiter
  import writeback_arbiter_unit_pkg::*;
#(
  parameter int p_width = 3,
  localparam int PW = ptr_bits(p_width)
) (
  input  logic [p_width-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [p_width-1:0] grant,
  output logic [PW-1:0]      grant_idx,
  output logic               gnt_any
);

  // Walk a doubled index range so every position is a constant
  // index; the window [ptr, ptr+p_width) is the wrapped search.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    gnt_any   = 1'b0;
    for (int k = 0; k < 2 * p_width; k++) begin
      if (!gnt_any
          && k >= int'(ptr)
          && k < int'(ptr) + p_width
          && req[k % p_width]) begin
        gnt_any              = 1'b1;
        grant[k % p_width]   = 1'b1;
        grant_idx            = PW'(k % p_width);
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter_unit.sv
// Writeback arbiter: merges N execute-pipe completions into one
// registered completion notification per cycle, round-robin.
// Ports: clk, rst; X_* per-pipe val/rdy stream (flattened);
// complete_* one-cycle publish to the decode-issue unit.
module writeback_arbiter_unit
  import writeback_arbiter_unit_pkg::*;
#(
  parameter int p_num_pipes    = 3,
  parameter int p_data_bits    = XLEN,
  parameter int p_seq_num_bits = SEQ_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                X_val,
  output logic [p_num_pipes-1:0]                X_rdy,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] X_seq_num,
  input  logic [p_num_pipes*REG_BITS-1:0]       X_waddr,
  input  logic [p_num_pipes*p_data_bits-1:0]    X_wdata,
  input  logic [p_num_pipes-1:0]                X_wen,
  output logic                                  complete_val,
  output logic [p_seq_num_bits-1:0]             complete_seq_num,
  output logic [REG_BITS-1:0]                   complete_waddr,
  output logic [p_data_bits-1:0]                complete_wdata,
  output logic                                  complete_wen
);

  localparam int PW = ptr_bits(p_num_pipes);
  localparam logic [PW-1:0] LAST = PW'(p_num_pipes - 1);

  typedef struct packed {
    logic [p_seq_num_bits-1:0] seq_num;
    logic [REG_BITS-1:0]       waddr;
    logic [p_data_bits-1:0]    wdata;
    logic                      wen;
  } msg_t;

  logic [PW-1:0]          ptr;
  logic [PW-1:0]          grant_idx;
  logic [p_num_pipes-1:0] req;
  logic [p_num_pipes-1:0] grant;
  logic                   gnt_any;
  logic                   val_q;
  msg_t                   sel;
  msg_t                   out_q;

  // Reset masks requests so no producer sees ready during reset.
  assign req = rst ? '0 : X_val;

  rr_arbiter #(
    .p_width (p_num_pipes)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .gnt_any   (gnt_any)
  );

  assign X_rdy = grant;

  // One-hot mux of the granted pipe's message.
  always_comb begin
    sel = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      if (grant[i]) begin
        sel.seq_num =
          X_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
        sel.waddr = X_waddr[i*REG_BITS +: REG_BITS];
        sel.wdata = X_wdata[i*p_data_bits +: p_data_bits];
        sel.wen   = rf_wen(X_wen[i],
                           X_waddr[i*REG_BITS +: REG_BITS]);
      end
    end
  end

  // Data fields hold when idle; only val pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      val_q <= 1'b0;
      out_q <= '0;
    end else begin
      val_q <= gnt_any;
      if (gnt_any) begin
        out_q <= sel;
        ptr   <= (grant_idx == LAST) ? '0
                                     : grant_idx + 1'b1;
      end
    end
  end

  assign complete_val     = val_q;
  assign complete_seq_num = out_q.seq_num;
  assign complete_waddr   = out_q.waddr;
  assign complete_wdata   = out_q.wdata;
  assign complete_wen     = out_q.wen;

  always_comb begin
    assert ($onehot0(X_rdy));
  end

endmodule

// File: tb/tb_writeback_arbiter_unit.sv
// Testbench for writeback_arbiter_unit (N=3 and N=1 instances).
// Randomized producers checked against a behavioural model.
module tb_writeback_arbiter_unit;
  import writeback_arbiter_unit_pkg::*;

  localparam int N  = 3;
  localparam int DB = XLEN;
  localparam int SB = SEQ_BITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]          X_val, X_rdy, X_wen;
  logic [N*SB-1:0]       X_seq_num;
  logic [N*REG_BITS-1:0] X_waddr;
  logic [N*DB-1:0]       X_wdata;
  logic                  complete_val, complete_wen;
  logic [SB-1:0]         complete_seq_num;
  logic [REG_BITS-1:0]   complete_waddr;
  logic [DB-1:0]         complete_wdata;

  logic                  v1, rdy1, c1_val, c1_wen;
  logic [SB-1:0]         c1_seq;
  logic [REG_BITS-1:0]   c1_waddr;
  logic [DB-1:0]         c1_wdata;

  writeback_arbiter_unit #(
    .p_num_pipes(N), .p_data_bits(DB), .p_seq_num_bits(SB)
  ) dut (
    .clk(clk), .rst(rst),
    .X_val(X_val), .X_rdy(X_rdy),
    .X_seq_num(X_seq_num), .X_waddr(X_waddr),
    .X_wdata(X_wdata), .X_wen(X_wen),
    .complete_val(complete_val),
    .complete_seq_num(complete_seq_num),
    .complete_waddr(complete_waddr),
    .complete_wdata(complete_wdata),
    .complete_wen(complete_wen)
  );

  // Producer state: pending message per pipe.
  logic pv[N];
  x_w_t pm[N];
  logic p1v;
  x_w_t p1m;

  writeback_arbiter_unit #(
    .p_num_pipes(1), .p_data_bits(DB), .p_seq_num_bits(SB)
  ) dut1 (
    .clk(clk), .rst(rst),
    .X_val(v1), .X_rdy(rdy1),
    .X_seq_num(p1m.seq_num), .X_waddr(p1m.waddr),
    .X_wdata(p1m.wdata), .X_wen(p1m.wen),
    .complete_val(c1_val),
    .complete_seq_num(c1_seq),
    .complete_waddr(c1_waddr),
    .complete_wdata(c1_wdata),
    .complete_wen(c1_wen)
  );

  assign v1 = p1v;

  always_comb begin
    X_val     = '0;
    X_wen     = '0;
    X_seq_num = '0;
    X_waddr   = '0;
    X_wdata   = '0;
    for (int i = 0; i < N; i++) begin
      X_val[i]                   = pv[i];
      X_wen[i]                   = pm[i].wen;
      X_seq_num[i*SB +: SB]      = pm[i].seq_num;
      X_waddr[i*REG_BITS +: REG_BITS] = pm[i].waddr;
      X_wdata[i*DB +: DB]        = pm[i].wdata;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int   mptr;
  bit   e_val, e1_val, chkf, chkf1;
  x_w_t e_out, e1_out;
  int   wcnt[N];
  int   seq_ctr;

  function automatic x_w_t rand_msg();
    x_w_t m;
    m.seq_num = SB'(seq_ctr);
    seq_ctr   = seq_ctr + 1;
    m.waddr   = ($urandom_range(3, 0) == 0) ? '0
                : REG_BITS'($urandom_range(31, 1));
    m.wdata   = $urandom;
    m.wen     = 1'($urandom_range(1, 0));
    return m;
  endfunction

  // One clock: ready check at negedge, outputs #1 after posedge.
  task automatic step(input bit refill);
    int g;
    logic [N-1:0] e_rdy;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int j = (mptr + k) % N;
        if (g < 0 && pv[j]) g = j;
      end
    end
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    chk("x_rdy", X_rdy, e_rdy);
    chk("onehot", $onehot0(X_rdy), 1);
    chk("rdy1", rdy1, (!rst && p1v));
    @(posedge clk);
    #1;
    if (rst) begin
      mptr = 0;
      e_val = 0;  e_out = '0;  chkf = 1;
      e1_val = 0; e1_out = '0; chkf1 = 1;
      for (int k = 0; k < N; k++) wcnt[k] = 0;
    end else begin
      e_val = (g >= 0);
      chkf  = e_val;
      if (g >= 0) begin
        e_out     = pm[g];
        e_out.wen = pm[g].wen && (pm[g].waddr != 0);
        mptr      = (g + 1) % N;
        chk("wait", (wcnt[g] <= N - 1), 1);
        wcnt[g] = 0;
        pv[g]   = 0;
      end
      for (int k = 0; k < N; k++)
        wcnt[k] = pv[k] ? wcnt[k] + 1 : 0;
      e1_val = p1v;
      chkf1  = p1v;
      if (p1v) begin
        e1_out     = p1m;
        e1_out.wen = p1m.wen && (p1m.waddr != 0);
        p1v        = 0;
      end
    end
    chk("val", complete_val, e_val);
    if (chkf) begin
      chk("seq", complete_seq_num, e_out.seq_num);
      chk("waddr", complete_waddr, e_out.waddr);
      chk("wdata", complete_wdata, e_out.wdata);
      chk("wen", complete_wen, e_out.wen);
    end
    chk("val1", c1_val, e1_val);
    if (chkf1) begin
      chk("seq1", c1_seq, e1_out.seq_num);
      chk("waddr1", c1_waddr, e1_out.waddr);
      chk("wdata1", c1_wdata, e1_out.wdata);
      chk("wen1", c1_wen, e1_out.wen);
    end
    if (refill) begin
      for (int k = 0; k < N; k++)
        if (!pv[k] && $urandom_range(1, 0) == 1) begin
          pv[k] = 1;
          pm[k] = rand_msg();
        end
      if (!p1v && $urandom_range(1, 0) == 1) begin
        p1v = 1;
        p1m = rand_msg();
      end
    end
  endtask

  initial begin
    rst = 1;
    p1v = 0;
    p1m = '0;
    seq_ctr = 0;
    mptr = 0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 0; pm[i] = '0; wcnt[i] = 0;
    end
    step(0);
    step(0);
    chk("rst_val", complete_val, 0);
    chk("rst_wdata", complete_wdata, 0);
    rst = 0;

    // Single-pipe instance.
    p1v = 1;
    p1m = '{seq_num: 5'd3, waddr: 5'd5,
            wdata: 32'h0000002A, wen: 1'b1};
    step(0);
    chk("n1_val", c1_val, 1);
    chk("n1_wdata", c1_wdata, 32'h2A);
    step(0);
    chk("n1_idle", c1_val, 0);

    // All pipes valid every cycle with seq 0/1/2.
    repeat (6) begin
      for (int i = 0; i < N; i++) begin
        pv[i] = 1;
        pm[i] = '{seq_num: SB'(i), waddr: REG_BITS'(i + 1),
                  wdata: $urandom, wen: 1'b1};
      end
      step(0);
    end
    for (int i = 0; i < N; i++) pv[i] = 0;

    // Move ptr to 1, then only pipes 0 and 2 valid.
    pv[0] = 1; pm[0] = rand_msg();
    step(0);
    pv[0] = 1; pm[0] = rand_msg(); pm[0].seq_num = 5'd10;
    pv[2] = 1; pm[2] = rand_msg(); pm[2].seq_num = 5'd12;
    step(0);
    chk("skip_p2", complete_seq_num, 12);
    step(0);
    chk("then_p0", complete_seq_num, 10);

    // Write to x0 is published with wen suppressed.
    pv[1] = 1;
    pm[1] = '{seq_num: 5'd9, waddr: 5'd0,
              wdata: 32'hDEADBEEF, wen: 1'b1};
    step(0);
    chk("x0_wen", complete_wen, 0);
    chk("x0_seq", complete_seq_num, 9);

    // Store with wen=0 still completes.
    pv[0] = 1;
    pm[0] = '{seq_num: 5'd7, waddr: 5'd3,
              wdata: 32'h1234, wen: 1'b0};
    step(0);
    chk("st_val", complete_val, 1);
    chk("st_wen", complete_wen, 0);

    // Reset right after a transfer.
    for (int i = 0; i < N; i++) begin
      pv[i] = 1; pm[i] = rand_msg();
    end
    step(0);
    rst = 1;
    step(0);
    chk("mid_rst_val", complete_val, 0);
    rst = 0;
    repeat (4) step(0);

    // Randomized traffic with occasional reset.
    repeat (3000) begin
      rst = ($urandom_range(199, 0) == 0);
      step(1);
    end
    rst = 0;
    repeat (8) step(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
